// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the riscv_mem two-port arbiter.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [1:0] BY_BYTE = 2'b00;
  localparam logic [1:0] BY_HALF = 2'b01;
  localparam logic [1:0] BY_WORD = 2'b10;

  localparam int LOCK_MAX_DEFAULT = 8;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of both requester ports plus the single-port memory side of the arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface riscv_mem_arbiter_if;

  logic        p0_req, p0_we, p0_lock;
  logic [1:0]  p0_by;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_done;
  logic [31:0] p0_rdata;

  logic        p1_req, p1_we, p1_lock;
  logic [1:0]  p1_by;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_done;
  logic [31:0] p1_rdata;

  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  mem_by;
  logic        mem_RE, mem_WE;

  modport master (
    output p0_req, p0_we, p0_lock, p0_by, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_by, p1_addr, p1_wdata,
    output mem_data_out,
    input  p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata,
    input  mem_addr, mem_data_in, mem_by, mem_RE, mem_WE
  );

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_by, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_by, p1_addr, p1_wdata,
    input  mem_data_out,
    output p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata,
    output mem_addr, mem_data_in, mem_by, mem_RE, mem_WE
  );

endinterface

// File: rtl/riscv_mem_arbiter_pick.sv
// Combinational winner selection for the arbiter's IDLE state.
// With MEM_ARB_RR_EN defined, a pointer input picks the preferred port on contention.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic [1:0]       req,
  input  logic             lock_act,
  input  logic             owner,
`ifdef MEM_ARB_RR_EN
  input  logic             rr_ptr,
`endif
  input  logic [CNT_W-1:0] lock_cnt,
  output logic             valid,
  output logic             winner,
  output logic             locked
);

  logic other;
  logic owner_req;
  logic other_req;
  logic contended_pick;

  assign other     = ~owner;
  assign owner_req = req[owner];
  assign other_req = req[other];

`ifdef MEM_ARB_RR_EN
  assign contended_pick = rr_ptr;
`else
  assign contended_pick = PORT0;
`endif

  // A held lock wins until the bound; at the bound the other requester takes over.
  always_comb begin
    valid  = |req;
    winner = PORT0;
    locked = 1'b0;
    if (lock_act && owner_req && (lock_cnt < CNT_W'(LOCK_MAX))) begin
      winner = owner;
      locked = 1'b1;
    end else if (lock_act && owner_req) begin
      winner = other_req ? other : owner;
    end else if (req == 2'b11) begin
      winner = contended_pick;
    end else begin
      winner = req[1] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port riscv_mem, one access per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed port-0 priority.
module riscv_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input logic                clk,
  input logic                reset_n,
  riscv_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state, state_n;
  logic             owner;
  logic             lock_act;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       req, lock;
  logic             pick_valid, pick_winner, pick_locked;
  logic             own_we, in_access, in_resp;
`ifdef MEM_ARB_RR_EN
  logic             rr_ptr;
`endif

  assign req  = {bus.p1_req, bus.p0_req};
  assign lock = {bus.p1_lock, bus.p0_lock};

  mem_arb_pick #(.LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) u_pick (
    .req      (req),
    .lock_act (lock_act),
    .owner    (owner),
`ifdef MEM_ARB_RR_EN
    .rr_ptr   (rr_ptr),
`endif
    .lock_cnt (lock_cnt),
    .valid    (pick_valid),
    .winner   (pick_winner),
    .locked   (pick_locked)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (pick_valid) state_n = ST_ACCESS;
      ST_ACCESS: state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Ownership and lock bookkeeping only change in IDLE, the sole arbitration point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= PORT0;
      lock_act <= 1'b0;
      lock_cnt <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr   <= PORT0;
`endif
    end else if (state == ST_IDLE) begin
      if (pick_valid) begin
        owner    <= pick_winner;
        lock_act <= lock[pick_winner];
        lock_cnt <= (pick_locked && lock[pick_winner]) ? lock_cnt + CNT_W'(1) : '0;
`ifdef MEM_ARB_RR_EN
        rr_ptr   <= ~pick_winner;
`endif
      end else if (lock_act && !req[owner]) begin
        lock_act <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

  assign in_access = (state == ST_ACCESS);
  assign in_resp   = (state == ST_RESP);
  assign own_we    = owner ? bus.p1_we : bus.p0_we;

  assign bus.mem_addr    = owner ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_by      = owner ? bus.p1_by    : bus.p0_by;
  assign bus.mem_data_in = owner ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_WE      = in_access && own_we;
  assign bus.mem_RE      = in_access && !own_we;

  assign bus.p0_gnt   = in_access && (owner == PORT0);
  assign bus.p1_gnt   = in_access && (owner == PORT1);
  assign bus.p0_done  = in_resp && (owner == PORT0);
  assign bus.p1_done  = in_resp && (owner == PORT1);
  // Writes complete with a done pulse but carry no read data.
  assign bus.p0_rdata = (bus.p0_done && !own_we) ? bus.mem_data_out : '0;
  assign bus.p1_rdata = (bus.p1_done && !own_we) ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed timing checks plus a
// transaction-level reference model feeding a scoreboard. Honours MEM_ARB_RR_EN.
module tb_riscv_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LOCK_MAX = 8;

  typedef struct packed {
    logic we; logic lock; logic [1:0] by; logic [31:0] addr; logic [31:0] wdata;
  } txn_t;
  typedef struct packed {
    logic port; logic we; logic [1:0] by; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  riscv_mem_arbiter_if bus();

  riscv_mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] dmem [0:255];
  logic [7:0] rmem [0:255];
  int   n_cmp = 0;
  int   n_err = 0;
  txn_t l0[$];
  txn_t l1[$];
  exp_t exp_q[$];
  logic glog[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic sb_en = 1'b0;
  int   gnt_count = 0;
  logic m_owner, m_lock, m_ptr;
  int   m_cnt;
  logic [3:0] pat [1:6];

  function automatic int nbytes(input logic [1:0] by);
    case (by)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Stand-in for riscv_mem: read data registered one cycle after mem_RE.
  always @(posedge clk) begin
    if (bus.mem_WE)
      for (int k = 0; k < nbytes(bus.mem_by); k++)
        dmem[8'(bus.mem_addr[7:0] + 8'(k))] <= bus.mem_data_in[8*k +: 8];
    if (bus.mem_RE)
      bus.mem_data_out <= {dmem[{bus.mem_addr[7:2], 2'b11}], dmem[{bus.mem_addr[7:2], 2'b10}],
                           dmem[{bus.mem_addr[7:2], 2'b01}], dmem[{bus.mem_addr[7:2], 2'b00}]};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setPort(input int p, input txn_t t, input logic req);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = t.we; bus.p0_lock = t.lock;
      bus.p0_by = t.by; bus.p0_addr = t.addr; bus.p0_wdata = t.wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = t.we; bus.p1_lock = t.lock;
      bus.p1_by = t.by; bus.p1_addr = t.addr; bus.p1_wdata = t.wdata;
    end
  endtask

  task automatic applyStimulus(input int p, input txn_t t);
    setPort(p, t, 1'b1);
  endtask

  function automatic txn_t mkTxn(input logic we, input logic lock, input logic [1:0] by,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.by = by; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t randTxn();
    return mkTxn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 2)), $urandom, $urandom);
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    setPort(0, '0, 1'b0);
    setPort(1, '0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 1'b0; m_lock = 1'b0; m_cnt = 0; m_ptr = 1'b0;
  endtask

  // Reference model: serve the two request lists one grant at a time by the
  // arbitration rules, tracking memory contents to predict read data.
  task automatic planRound(input int start0);
    int i0 = 0, i1 = 0, n = 0;
    logic [1:0] r;
    logic w, locked;
    txn_t t;
    exp_t e;
    while (i0 < l0.size() || i1 < l1.size()) begin
      r[0] = (i0 < l0.size()) && (n >= start0);
      r[1] = (i1 < l1.size());
      if (r == 2'b00) break;
      locked = 1'b0;
      if (m_lock && r[m_owner] && m_cnt < LOCK_MAX) begin
        w = m_owner; locked = 1'b1;
      end else if (m_lock && r[m_owner]) begin
        w = r[!m_owner] ? !m_owner : m_owner;
      end else if (r == 2'b11) begin
`ifdef MEM_ARB_RR_EN
        w = m_ptr;
`else
        w = 1'b0;
`endif
      end else begin
        w = r[1];
      end
      if (w) begin t = l1[i1]; i1++; end
      else   begin t = l0[i0]; i0++; end
      m_cnt   = (locked && t.lock) ? m_cnt + 1 : 0;
      m_lock  = t.lock;
      m_owner = w;
      m_ptr   = !w;
      e.port = w; e.we = t.we; e.by = t.by; e.addr = t.addr; e.wdata = t.wdata;
      if (t.we) begin
        for (int k = 0; k < nbytes(t.by); k++) rmem[8'(t.addr[7:0] + 8'(k))] = t.wdata[8*k +: 8];
        e.rdata = '0;
      end else begin
        e.rdata = {rmem[{t.addr[7:2], 2'b11}], rmem[{t.addr[7:2], 2'b10}],
                   rmem[{t.addr[7:2], 2'b01}], rmem[{t.addr[7:2], 2'b00}]};
      end
      exp_q.push_back(e);
      n++;
    end
    m_lock = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic drivePort(input int p, input int start);
    txn_t list[$];
    int w;
    list = (p == 0) ? l0 : l1;
    if (list.size() == 0) return;
    if (start > 0) begin
      w = 0;
      while (gnt_count < start && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) begin n_cmp++; n_err++; $display("[TB] FAIL start_wait p%0d: no grant seen", p); end
    end
    foreach (list[i]) begin
      applyStimulus(p, list[i]);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!((p == 0) ? bus.p0_done : bus.p1_done) && w < 200);
      if (w >= 200) begin n_cmp++; n_err++; $display("[TB] FAIL done_wait p%0d: no done", p); end
      @(posedge clk);
      #1;
    end
    setPort(p, '0, 1'b0);
  endtask

  task automatic runRound(input int start0);
    glog.delete();
    gnt_count = 0;
    planRound(start0);
    fork
      drivePort(0, start0);
      drivePort(1, 0);
    join
    repeat (4) @(negedge clk);
    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the model's next expected transaction at each grant.
  always @(negedge clk) begin
    if (sb_en && reset_n) begin
      if (bus.p0_gnt || bus.p1_gnt) begin
        gnt_count++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL unexpected_gnt: p0_gnt=%b p1_gnt=%b, expected none", bus.p0_gnt, bus.p1_gnt);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          glog.push_back(bus.p1_gnt);
          checkOutput("gnt_port", 32'({bus.p1_gnt, bus.p0_gnt}), cur.port ? 32'd2 : 32'd1);
          checkOutput("mem_addr", bus.mem_addr, cur.addr);
          checkOutput("mem_by", 32'(bus.mem_by), 32'(cur.by));
          checkOutput("mem_strobes", 32'({bus.mem_WE, bus.mem_RE}), cur.we ? 32'd2 : 32'd1);
          if (cur.we) checkOutput("mem_data_in", bus.mem_data_in, cur.wdata);
        end
      end
      if (bus.p0_done || bus.p1_done) begin
        if (!have_cur) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL unexpected_done: p0_done=%b p1_done=%b, expected none", bus.p0_done, bus.p1_done);
        end else begin
          checkOutput("done_port", 32'({bus.p1_done, bus.p0_done}), cur.port ? 32'd2 : 32'd1);
          checkOutput("rdata", cur.port ? bus.p1_rdata : bus.p0_rdata, cur.rdata);
          checkOutput("other_rdata", cur.port ? bus.p0_rdata : bus.p1_rdata, 32'd0);
          have_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    int lead, waited;
    logic [3:0] order;
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end
    {dmem[8'h13], dmem[8'h12], dmem[8'h11], dmem[8'h10]} = 32'hDEADBEEF;
    {rmem[8'h13], rmem[8'h12], rmem[8'h11], rmem[8'h10]} = 32'hDEADBEEF;
    setPort(0, mkTxn(1'b0, 1'b0, 2'b01, 32'h0000_00A4, 32'hCAFE_0001), 1'b0);
    setPort(1, mkTxn(1'b1, 1'b0, 2'b10, 32'h0000_00B0, 32'h1111_2222), 1'b0);

    #12;
    checkOutput("rst_gnt",   32'({bus.p0_gnt, bus.p1_gnt}), 32'd0);
    checkOutput("rst_done",  32'({bus.p0_done, bus.p1_done}), 32'd0);
    checkOutput("rst_strb",  32'({bus.mem_RE, bus.mem_WE}), 32'd0);
    checkOutput("rst_rdata0", bus.p0_rdata, 32'd0);
    checkOutput("rst_rdata1", bus.p1_rdata, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0000_00A4);
    checkOutput("rst_mem_by", 32'(bus.mem_by), 32'd1);
    checkOutput("rst_mem_din", bus.mem_data_in, 32'hCAFE_0001);
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 1'b0; m_lock = 1'b0; m_cnt = 0; m_ptr = 1'b0;
    setPort(0, '0, 1'b0);
    setPort(1, '0, 1'b0);

    // Single read: gnt/RE in cycle 1, done with data in cycle 2.
    @(negedge clk);
    applyStimulus(0, mkTxn(1'b0, 1'b0, BY_WORD, 32'h10, 32'h0));
    @(negedge clk);
    checkOutput("rd_gnt", 32'({bus.p0_gnt, bus.p1_gnt, bus.mem_RE, bus.mem_WE}), 32'b1010);
    checkOutput("rd_addr", bus.mem_addr, 32'h10);
    @(negedge clk);
    checkOutput("rd_done", 32'({bus.p0_done, bus.p1_done}), 32'b10);
    checkOutput("rd_data", bus.p0_rdata, 32'hDEADBEEF);
    checkOutput("rd_p1_rdata", bus.p1_rdata, 32'd0);
    @(posedge clk);
    #1 setPort(0, '0, 1'b0);

    // Simultaneous one-shot requests from a fresh reset: {p0_gnt,p0_done,p1_gnt,p1_done}.
    pat[1] = 4'b1000; pat[2] = 4'b0100; pat[3] = 4'b0000;
    pat[4] = 4'b0010; pat[5] = 4'b0001; pat[6] = 4'b0000;
    doReset();
    applyStimulus(0, mkTxn(1'b0, 1'b0, BY_WORD, 32'h10, 32'h0));
    applyStimulus(1, mkTxn(1'b0, 1'b0, BY_WORD, 32'h14, 32'h0));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("simul_c%0d", c),
                  32'({bus.p0_gnt, bus.p0_done, bus.p1_gnt, bus.p1_done}), 32'(pat[c]));
      if (c == 3) setPort(0, '0, 1'b0);
      if (c == 6) setPort(1, '0, 1'b0);
    end

    // Reset during ACCESS of a p0 read aborts it; the held request is re-granted after release.
    applyStimulus(0, mkTxn(1'b0, 1'b0, BY_WORD, 32'h10, 32'h0));
    @(negedge clk);
    checkOutput("abort_pre_gnt", 32'(bus.p0_gnt), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_gnt_re", 32'({bus.p0_gnt, bus.mem_RE}), 32'd0);
    @(negedge clk);
    checkOutput("abort_no_done", 32'(bus.p0_done), 32'd0);
    reset_n = 1'b1;
    m_owner = 1'b0; m_lock = 1'b0; m_cnt = 0; m_ptr = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.p0_gnt && waited < 6);
    checkOutput("regrant_within_2", 32'(waited >= 1 && waited <= 2), 32'd1);
    @(negedge clk);
    checkOutput("regrant_done", 32'(bus.p0_done), 32'd1);
    checkOutput("regrant_data", bus.p0_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1 setPort(0, '0, 1'b0);

    // Scoreboard phase.
    doReset();
    sb_en = 1'b1;
    l0.delete(); l1.delete();
    l1.push_back(mkTxn(1'b1, 1'b0, BY_WORD, 32'h20, 32'h12345678));
    runRound(0);
    l1.delete();
    l0.push_back(mkTxn(1'b0, 1'b0, BY_WORD, 32'h20, 32'h0));
    runRound(0);

    // Lock bound: p1 holds a lock, p0 joins after p1's first grant.
    l0.delete(); l1.delete();
    l0.push_back(mkTxn(1'b0, 1'b0, BY_WORD, 32'h40, 32'h0));
    for (int i = 0; i < 10; i++) l1.push_back(mkTxn(1'b0, 1'b1, BY_WORD, 32'h100 + 32'(4 * i), 32'h0));
    runRound(1);
    lead = 0;
    while (lead < glog.size() && glog[lead]) lead++;
    checkOutput("lock_run_len", 32'(lead), 32'd9);
    checkOutput("lock_break_p0", (glog.size() > 9) ? 32'(glog[9]) : 32'hFFFF_FFFF, 32'd0);

    // Continuous contention for four transactions.
    doReset();
    l0.delete(); l1.delete();
    for (int i = 0; i < 2; i++) begin
      l0.push_back(mkTxn(1'b0, 1'b0, BY_WORD, 32'h60 + 32'(4 * i), 32'h0));
      l1.push_back(mkTxn(1'b0, 1'b0, BY_WORD, 32'h70 + 32'(4 * i), 32'h0));
    end
    runRound(0);
    order = (glog.size() == 4) ? {glog[0], glog[1], glog[2], glog[3]} : 4'hF;
`ifdef MEM_ARB_RR_EN
    checkOutput("grant_order", 32'(order), 32'b0101);
`else
    checkOutput("grant_order", 32'(order), 32'b0011);
`endif

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      l0.delete(); l1.delete();
      repeat ($urandom_range(0, 3)) l0.push_back(randTxn());
      repeat ($urandom_range(0, 3)) l1.push_back(randTxn());
      runRound(0);
    end
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
